// File: rtl/arm_pkg.sv
// Shared ARM ISA definitions: condition-code encodings and NZCV flag bit positions.
package arm_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an instruction condition field against stored NZCV flags.
module cond_check
   import arm_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   always_comb begin
      CondEx = 1'b0;
      case (cond_e'(Cond))
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = c & ~z;
         COND_LS: CondEx = ~c | z;
         COND_GE: CondEx = (n == v);
         COND_LT: CondEx = (n != v);
         COND_GT: CondEx = ~z & (n == v);
         COND_LE: CondEx = z | (n != v);
         COND_AL: CondEx = 1'b1;
         COND_NV: CondEx = 1'b0;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/conditional_logic.sv
// Conditional-execution unit: holds NZCV in two separately enabled groups and gates
// the decoder's PC, register and memory write requests with the evaluated condition.
module conditional_logic
   import arm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic [1:0] FlagW,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite
);

   logic [1:0] nz_q, nz_d;
   logic [1:0] cv_q, cv_d;
   logic [3:0] flags;
   logic       cond_ex;
   logic [1:0] flag_write;

   assign flags = {nz_q, cv_q};

   cond_check u_cond_check (
      .Cond   (Cond),
      .Flags  (flags),
      .CondEx (cond_ex)
   );

   // Evaluation uses stored flags only, so an update is visible from the next cycle.
   assign flag_write = FlagW & {cond_ex, cond_ex};

   always_comb begin
      nz_d = nz_q;
      cv_d = cv_q;
      if (flag_write[1]) nz_d = ALUFlags[FLAG_N:FLAG_Z];
      if (flag_write[0]) cv_d = ALUFlags[FLAG_C:FLAG_V];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nz_q <= '0;
         cv_q <= '0;
      end else begin
         nz_q <= nz_d;
         cv_q <= cv_d;
      end
   end

   assign PCSrc    = PCS  & cond_ex;
   assign RegWrite = RegW & cond_ex;
   assign MemWrite = MemW & cond_ex;

endmodule

// File: tb/tb_conditional_logic.sv
// Directed self-checking bench for conditional_logic.
module tb_conditional_logic;

   logic       clk;
   logic       rst;
   logic       PCS;
   logic       RegW;
   logic       MemW;
   logic [1:0] FlagW;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic       PCSrc;
   logic       RegWrite;
   logic       MemWrite;

   int unsigned n_cmp;
   int unsigned n_err;

   conditional_logic dut (
      .clk      (clk),
      .rst      (rst),
      .PCS      (PCS),
      .RegW     (RegW),
      .MemW     (MemW),
      .FlagW    (FlagW),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .PCSrc    (PCSrc),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v;
      n = f[3]; z = f[2]; cc = f[1]; v = f[0];
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cc;
         4'h3: return !cc;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cc && !z;
         4'h9: return !cc || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                        input logic pcs, input logic regw, input logic memw);
      Cond = c; FlagW = fw; ALUFlags = alu; PCS = pcs; RegW = regw; MemW = memw;
   endtask

   // Loads flags through an AL instruction, returning 1 ns after the capturing edge.
   task automatic load_flags(input logic [3:0] f);
      @(negedge clk);
      drive(4'hE, 2'b11, f, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      drive(4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0;
      drive(4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
      #12;
      check("reset_flags", dut.flags, 4'b0000);
      @(negedge clk);
      rst = 1'b1;

      // EQ fails with Z=0: writes and flag update suppressed
      drive(4'h0, 2'b11, 4'b0100, 1'b1, 1'b0, 1'b1);
      #1;
      check("eq_fail_pcsrc", {3'b0, PCSrc}, 4'b0);
      check("eq_fail_memwrite", {3'b0, MemWrite}, 4'b0);
      @(posedge clk);
      #1;
      check("eq_fail_flags", dut.flags, 4'b0000);

      // AL executes and updates flags; EQ then sees Z=1 the next cycle
      @(negedge clk);
      drive(4'hE, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0);
      #1;
      check("al_regwrite", {3'b0, RegWrite}, 4'b1);
      @(posedge clk);
      #1;
      check("al_flags", dut.flags, 4'b0100);
      drive(4'h0, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0);
      #1;
      check("eq_pass_pcsrc", {3'b0, PCSrc}, 4'b1);

      // Partial group writes
      load_flags(4'b0000);
      check("partial_clear", dut.flags, 4'b0000);
      @(negedge clk);
      drive(4'hE, 2'b01, 4'b1111, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("partial_cv", dut.flags, 4'b0011);
      drive(4'hE, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("partial_nz", dut.flags, 4'b1111);

      // Full condition table sweep
      for (int unsigned f = 0; f < 16; f++) begin
         load_flags(4'(f));
         for (int unsigned c = 0; c < 16; c++) begin
            drive(4'(c), 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
            #1;
            check($sformatf("sweep_f%0h_c%0h", f, c), {3'b0, RegWrite},
                  {3'b0, ref_cond(4'(c), 4'(f))});
         end
      end

      // Asynchronous reset mid-cycle, held across an edge with a pending update
      load_flags(4'b1010);
      check("pre_async_flags", dut.flags, 4'b1010);
      @(negedge clk);
      drive(4'hE, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_flags", dut.flags, 4'b0000);
      @(posedge clk);
      #1;
      check("rst_hold_flags", dut.flags, 4'b0000);
      drive(4'hA, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
      #1;
      check("rst_ge_regwrite", {3'b0, RegWrite}, 4'b1);
      @(negedge clk);
      rst = 1'b1;

      // GT / LE with N=1, Z=0, V=1
      load_flags(4'b1001);
      drive(4'hC, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
      #1;
      check("gt_regwrite", {3'b0, RegWrite}, 4'b1);
      drive(4'hD, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0);
      #1;
      check("le_regwrite", {3'b0, RegWrite}, 4'b0);
      @(posedge clk);
      #1;
      check("le_no_update", dut.flags, 4'b1001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

endmodule
